// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART receive shared types, prescale constants and legality check
//
// Contents:
//   rx_state_e    receive FSM states
//   PRESC_*       supported oversampling ratios
//   BIT_CNT_W     width of the frame bit counter (covers data + parity bits)
//   presc_legal() 1 when a Prescale value is one of the supported ratios
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_e;

   localparam logic [5:0] PRESC_4  = 6'd4;
   localparam logic [5:0] PRESC_8  = 6'd8;
   localparam logic [5:0] PRESC_16 = 6'd16;
   localparam logic [5:0] PRESC_32 = 6'd32;

   localparam int BIT_CNT_W = 4;

   function automatic logic presc_legal(input logic [5:0] presc);
      return (presc == PRESC_4) || (presc == PRESC_8) ||
             (presc == PRESC_16) || (presc == PRESC_32);
   endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// rtl/uart_rx_edge_bit_cnt.sv - oversample edge counter and frame bit counter
//
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   enable     count oversample edges (FSM outside IDLE)
//   clear      zero both counters this cycle (has priority over enable)
//   pre_q      latched oversampling ratio
//   edge_cnt   oversample edge index within the current bit, wraps at pre_q-1
//   bit_cnt    bits completed since the last clear
//   bit_end    edge_cnt is on the last oversample edge of the bit
module uart_rx_edge_bit_cnt
   import uart_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 clear,
   input  logic [5:0]           pre_q,
   output logic [4:0]           edge_cnt,
   output logic [BIT_CNT_W-1:0] bit_cnt,
   output logic                 bit_end
);

   assign bit_end = enable && ({1'b0, edge_cnt} == (pre_q - 6'd1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         edge_cnt <= '0;
         bit_cnt  <= '0;
      end else if (clear) begin
         edge_cnt <= '0;
         bit_cnt  <= '0;
      end else if (enable) begin
         if (bit_end) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_cnt + 1'b1;
         end else begin
            edge_cnt <= edge_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive frame sequencer, deserializer and error checks
//
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   RX_IN         serial line, idle high
//   PAR_EN        frame carries a parity bit
//   PAR_TYP       0 even, 1 odd parity
//   Prescale      oversampling ratio (4/8/16/32 accepted)
//   sampled_bit   majority-voted bit returned by the sampler
//   data_samp_en  sampler enable (FSM outside IDLE)
//   edge_cnt      oversample edge index within the current bit
//   P_DATA        last good byte, LSB received first
//   data_valid    1-cycle pulse when P_DATA takes a good frame
//   par_err       1-cycle pulse on parity mismatch
//   stp_err       1-cycle pulse when the stop bit samples 0
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              RX_IN,
   input  logic              PAR_EN,
   input  logic              PAR_TYP,
   input  logic [5:0]        Prescale,
   input  logic              sampled_bit,
   output logic              data_samp_en,
   output logic [4:0]        edge_cnt,
   output logic [DATA_W-1:0] P_DATA,
   output logic              data_valid,
   output logic              par_err,
   output logic              stp_err
);

   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);

   rx_state_e             state_q, state_d;
   logic [5:0]            pre_q;
   logic [DATA_W-1:0]     shift_q;
   logic                  par_typ_q;
   logic                  frame_err_q;
   logic                  cnt_clear;
   logic                  bit_end;
   logic [BIT_CNT_W-1:0]  bit_cnt;

   assign data_samp_en = (state_q != IDLE);

   uart_rx_edge_bit_cnt u_cnt (
      .clk      (clk),
      .rst      (rst),
      .enable   (data_samp_en),
      .clear    (cnt_clear),
      .pre_q    (pre_q),
      .edge_cnt (edge_cnt),
      .bit_cnt  (bit_cnt),
      .bit_end  (bit_end)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Counters are cleared while idle and at the end of START and STOP, so
   // bit_cnt counts data bits from 0 and a back-to-back start begins at edge 0.
   always_comb begin
      state_d   = state_q;
      cnt_clear = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_clear = 1'b1;
            if (!RX_IN && presc_legal(Prescale)) state_d = START;
         end
         START: begin
            if (bit_end) begin
               cnt_clear = 1'b1;
               state_d   = sampled_bit ? IDLE : DATA;
            end
         end
         DATA: begin
            if (bit_end && (bit_cnt == LAST_BIT)) state_d = PAR_EN ? PARITY : STOP;
         end
         PARITY: begin
            if (bit_end) state_d = STOP;
         end
         STOP: begin
            if (bit_end) begin
               cnt_clear = 1'b1;
               state_d   = RX_IN ? IDLE : START;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre_q       <= '0;
         shift_q     <= '0;
         par_typ_q   <= 1'b0;
         frame_err_q <= 1'b0;
         P_DATA      <= '0;
         data_valid  <= 1'b0;
         par_err     <= 1'b0;
         stp_err     <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;

         if ((state_q == IDLE) && (state_d == START)) pre_q <= Prescale;

         if ((state_q == DATA) && bit_end) begin
            shift_q <= {sampled_bit, shift_q[DATA_W-1:1]};
            // Parity type is frozen as the last data bit completes.
            if (state_d != DATA) par_typ_q <= PAR_TYP;
         end

         if ((state_q == PARITY) && bit_end &&
             (sampled_bit != (^shift_q ^ par_typ_q))) begin
            par_err     <= 1'b1;
            frame_err_q <= 1'b1;
         end

         if ((state_q == STOP) && bit_end) begin
            frame_err_q <= 1'b0;
            if (!sampled_bit) begin
               stp_err <= 1'b1;
            end else if (!frame_err_q) begin
               P_DATA     <= shift_q;
               data_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       RX_IN = 1'b1;
   logic       PAR_EN = 1'b0;
   logic       PAR_TYP = 1'b0;
   logic [5:0] Prescale = 6'd8;
   logic       sampled_bit;
   logic       data_samp_en;
   logic [4:0] edge_cnt;
   logic [7:0] P_DATA;
   logic       data_valid;
   logic       par_err;
   logic       stp_err;

   uart_rx_ctrl #(.DATA_W(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .RX_IN        (RX_IN),
      .PAR_EN       (PAR_EN),
      .PAR_TYP      (PAR_TYP),
      .Prescale     (Prescale),
      .sampled_bit  (sampled_bit),
      .data_samp_en (data_samp_en),
      .edge_cnt     (edge_cnt),
      .P_DATA       (P_DATA),
      .data_valid   (data_valid),
      .par_err      (par_err),
      .stp_err      (stp_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Majority-vote sampler: three samples just before mid-bit, all
   // registered well before the bit-end edge.
   logic [2:0] smp = 3'b111;
   always @(posedge clk) begin
      if (data_samp_en) begin
         if (int'(edge_cnt) == int'(Prescale) / 2 - 2) smp[0] <= RX_IN;
         if (int'(edge_cnt) == int'(Prescale) / 2 - 1) smp[1] <= RX_IN;
         if (int'(edge_cnt) == int'(Prescale) / 2)     smp[2] <= RX_IN;
      end
   end
   assign sampled_bit = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);

   int dv_cnt = 0, pe_cnt = 0, se_cnt = 0, dv_cyc = 0, dv_prev = 0;
   always @(negedge clk) begin
      if (data_valid) begin
         dv_cnt  <= dv_cnt + 1;
         dv_prev <= dv_cyc;
         dv_cyc  <= cyc;
      end
      if (par_err) pe_cnt <= pe_cnt + 1;
      if (stp_err) se_cnt <= se_cnt + 1;
   end

   int errs = 0, checks = 0;
   int dv0, pe0, se0, st;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic snap();
      dv0 = dv_cnt;
      pe0 = pe_cnt;
      se0 = se_cnt;
   endtask

   task automatic send_frame(input logic [7:0] d, input bit has_par,
                             input bit par_bit, input bit stop_bit);
      RX_IN = 1'b0;
      tick(int'(Prescale));
      for (int i = 0; i < 8; i++) begin
         RX_IN = d[i];
         tick(int'(Prescale));
      end
      if (has_par) begin
         RX_IN = par_bit;
         tick(int'(Prescale));
      end
      RX_IN = stop_bit;
      tick(int'(Prescale));
   endtask

   initial begin
      tick(3);
      chk("rst_pdata", int'(P_DATA), 0);
      chk("rst_dv", int'(data_valid), 0);
      chk("rst_perr", int'(par_err), 0);
      chk("rst_serr", int'(stp_err), 0);
      chk("rst_samp_en", int'(data_samp_en), 0);
      chk("rst_edge", int'(edge_cnt), 0);
      rst = 1'b1;
      tick(4);

      // 0xA5, Prescale 8, no parity; pulse 81 clk after the start edge
      Prescale = 6'd8; PAR_EN = 1'b0;
      snap(); st = cyc;
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
      RX_IN = 1'b1; tick(12);
      chk("t1_dv", dv_cnt - dv0, 1);
      chk("t1_pdata", int'(P_DATA), 'hA5);
      chk("t1_perr", pe_cnt - pe0, 0);
      chk("t1_serr", se_cnt - se0, 0);
      chk("t1_latency", dv_cyc - st, 81);

      // 0x3C even parity, good then bad parity
      Prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
      snap();
      send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
      RX_IN = 1'b1; tick(20);
      chk("t2_dv", dv_cnt - dv0, 1);
      chk("t2_pdata", int'(P_DATA), 'h3C);
      chk("t2_perr", pe_cnt - pe0, 0);
      snap();
      send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
      RX_IN = 1'b1; tick(20);
      chk("t2b_dv", dv_cnt - dv0, 0);
      chk("t2b_perr", pe_cnt - pe0, 1);
      chk("t2b_serr", se_cnt - se0, 0);
      chk("t2b_pdata", int'(P_DATA), 'h3C);

      // 0x81 with stop bit 0 at Prescale 4
      Prescale = 6'd4; PAR_EN = 1'b0;
      snap();
      send_frame(8'h81, 1'b0, 1'b0, 1'b0);
      RX_IN = 1'b1; tick(10);
      chk("t3_serr", se_cnt - se0, 1);
      chk("t3_dv", dv_cnt - dv0, 0);
      chk("t3_perr", pe_cnt - pe0, 0);
      chk("t3_pdata", int'(P_DATA), 'h3C);
      chk("t3_idle", int'(data_samp_en), 0);

      // 2-clk glitch at Prescale 8: START, edge 7, then IDLE
      Prescale = 6'd8;
      snap();
      RX_IN = 1'b0; tick(2);
      RX_IN = 1'b1;
      chk("t4_start", int'(data_samp_en), 1);
      tick(6);
      chk("t4_edge7", int'(edge_cnt), 7);
      chk("t4_still", int'(data_samp_en), 1);
      tick(1);
      chk("t4_idle", int'(data_samp_en), 0);
      tick(10);
      chk("t4_pulses", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0), 0);

      // back-to-back 0x00, 0xFF at Prescale 32, odd parity
      Prescale = 6'd32; PAR_EN = 1'b1; PAR_TYP = 1'b1;
      snap();
      send_frame(8'h00, 1'b1, 1'b1, 1'b1);
      send_frame(8'hFF, 1'b1, 1'b1, 1'b1);
      RX_IN = 1'b1; tick(40);
      chk("t5_dv", dv_cnt - dv0, 2);
      chk("t5_gap", dv_cyc - dv_prev, 352);
      chk("t5_pdata", int'(P_DATA), 'hFF);
      chk("t5_errs", (pe_cnt - pe0) + (se_cnt - se0), 0);

      // illegal Prescale holds IDLE
      Prescale = 6'd6; PAR_EN = 1'b0; PAR_TYP = 1'b0;
      RX_IN = 1'b0; tick(10);
      chk("t6_samp_en", int'(data_samp_en), 0);
      chk("t6_edge", int'(edge_cnt), 0);
      RX_IN = 1'b1; tick(2);
      Prescale = 6'd8;
      tick(2);

      // reset during data bit 4, then a clean 0x5A
      snap();
      RX_IN = 1'b0; tick(8);
      for (int i = 0; i < 4; i++) begin
         RX_IN = (8'h5A >> i) & 8'h01;
         tick(8);
      end
      RX_IN = 1'b1; tick(4);
      chk("t6r_busy", int'(data_samp_en), 1);
      rst = 1'b0;
      #1;
      chk("t6r_pdata", int'(P_DATA), 0);
      chk("t6r_samp_en", int'(data_samp_en), 0);
      chk("t6r_edge", int'(edge_cnt), 0);
      chk("t6r_dv", int'(data_valid), 0);
      tick(2);
      rst = 1'b1; RX_IN = 1'b1;
      tick(4);
      send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
      RX_IN = 1'b1; tick(12);
      chk("t6c_dv", dv_cnt - dv0, 1);
      chk("t6c_pdata", int'(P_DATA), 'h5A);
      chk("t6c_errs", (pe_cnt - pe0) + (se_cnt - se0), 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
